rgb_video_pipe: RTL

//  Parametrised successor to the plain RGB loopback in the DVI test DUT.

---
 rtl/rgb_video_pkg.sv | 22 ++
 rtl/rgb_delay_line.sv | 36 +++
 rtl/rgb_video_pipe.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rgb_video_pkg.sv
// Shared types and helpers for the RGB video pipe.
package rgb_video_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_INV   = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_BLACK = 2'd3
  } mode_e;

  localparam int unsigned BAR_COUNT = 8;

  // Bar code bit 2 drives R, bit 1 drives G, bit 0 drives B; channels >= 3 repeat c%3.
  function automatic logic bar_colour(input logic [2:0] bar, input int unsigned c);
    case (c % 3)
      0:       return bar[2];
      1:       return bar[1];
      default: return bar[0];
    endcase
  endfunction

endpackage

// File: rtl/rgb_delay_line.sv
// Fixed-depth shift-register delay with synchronous reset.
module rgb_delay_line #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];

  // Next state: shift every stage one position towards the output.
  always_comb begin
    sr_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Stage registers, flushed to zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/rgb_video_pipe.sv
// RGB video delay pipe with per-frame pixel mode and raw-timing frame measurement.
module rgb_video_pipe
  import rgb_video_pkg::*;
#(
  parameter int unsigned BPC       = 8,
  parameter int unsigned NCH       = 3,
  parameter int unsigned DELAY     = 2,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned BAR_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 rgb_in_vsync,
  input  logic                 rgb_in_hsync,
  input  logic                 rgb_in_de,
  input  logic [NCH*BPC-1:0]   rgb_in_data,
  output logic                 rgb_out_vsync,
  output logic                 rgb_out_hsync,
  output logic                 rgb_out_de,
  output logic [NCH*BPC-1:0]   rgb_out_data,
  output logic [CNT_W-1:0]     meas_h_active,
  output logic [CNT_W-1:0]     meas_v_active,
  output logic                 meas_valid,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned DW = NCH * BPC;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  mode_e            act_mode_q, act_mode_d;
  logic             vs_q, de_q;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] meas_h_q, meas_h_d;
  logic [CNT_W-1:0] meas_v_q, meas_v_d;
  logic             meas_valid_q, meas_valid_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             vs_rise, de_fall;
  logic [CNT_W-1:0] x_cur;
  logic [2:0]       bar;
  logic [DW-1:0]    data_s0;

  assign vs_rise = rgb_in_vsync & ~vs_q;
  assign de_fall = de_q & ~rgb_in_de;

  // x_cnt_q holds the index of the previous de pixel, so the current index is derived
  // combinationally and the last index is still available on the de falling cycle.
  assign x_cur = de_q ? sat_inc(x_cnt_q) : '0;
  assign bar   = 3'(BAR_COUNT - 1) - 3'((x_cur >> BAR_SHIFT) % BAR_COUNT);

  // Stage-0 pixel function; blanking data always passes through untouched.
  always_comb begin
    data_s0 = rgb_in_data;
    if (rgb_in_de) begin
      case (act_mode_q)
        MODE_INV:   data_s0 = ~rgb_in_data;
        MODE_BARS: begin
          for (int unsigned c = 0; c < NCH; c++) begin
            data_s0[c*BPC +: BPC] = {BPC{bar_colour(bar, c)}};
          end
        end
        MODE_BLACK: data_s0 = '0;
        default:    data_s0 = rgb_in_data;
      endcase
    end
  end

  rgb_delay_line #(
    .W     (3 + DW),
    .DEPTH (DELAY)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({rgb_in_vsync, rgb_in_hsync, rgb_in_de, data_s0}),
    .q     ({rgb_out_vsync, rgb_out_hsync, rgb_out_de, rgb_out_data})
  );

  // Measurement and mode next state; a line ending on the vsync edge is folded in first.
  always_comb begin
    act_mode_d   = act_mode_q;
    x_cnt_d      = rgb_in_de ? x_cur : '0;
    line_len_d   = line_len_q;
    line_cnt_d   = line_cnt_q;
    armed_d      = armed_q;
    meas_h_d     = meas_h_q;
    meas_v_d     = meas_v_q;
    meas_valid_d = meas_valid_q;
    frame_cnt_d  = frame_cnt_q;
    if (de_fall) begin
      line_len_d = sat_inc(x_cnt_q);
      line_cnt_d = sat_inc(line_cnt_q);
    end
    if (vs_rise) begin
      act_mode_d  = mode_e'(mode);
      meas_h_d    = line_len_d;
      meas_v_d    = line_cnt_d;
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (!armed_q) begin
        armed_d = 1'b1;
      end else begin
        meas_valid_d = (line_cnt_d != '0);
      end
      line_cnt_d = '0;
    end
  end

  // Control and measurement registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_mode_q   <= MODE_PASS;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      x_cnt_q      <= '0;
      line_len_q   <= '0;
      line_cnt_q   <= '0;
      armed_q      <= 1'b0;
      meas_h_q     <= '0;
      meas_v_q     <= '0;
      meas_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      act_mode_q   <= act_mode_d;
      vs_q         <= rgb_in_vsync;
      de_q         <= rgb_in_de;
      x_cnt_q      <= x_cnt_d;
      line_len_q   <= line_len_d;
      line_cnt_q   <= line_cnt_d;
      armed_q      <= armed_d;
      meas_h_q     <= meas_h_d;
      meas_v_q     <= meas_v_d;
      meas_valid_q <= meas_valid_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign meas_h_active = meas_h_q;
  assign meas_v_active = meas_v_q;
  assign meas_valid    = meas_valid_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
